// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// ID-stage hazard and flow-control unit. It sits between the IF/ID and ID/EX
// pipeline registers and resolves the following conditions, highest priority
// first:
//   1. cache stall
//   2. taken branch
//   3. multi-cycle flush
//   4. load-use bubble
//   5. halt
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   When defined, the unit carries saturating load-use and flush performance
//   counters. When it is undefined, both counter outputs are tied to zero and
//   no counter flops are built.
//
// Parameters
//   FLUSH_CYCLES : IF/ID + ID/EX squash cycles after a taken branch (1..7)
//   CNT_W        : performance counter width
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   cache_stall_n     : 0 = cache miss in progress, freeze the pipeline
//   id_src_reg1/2     : ID-stage source registers
//   id_uses_src1/2    : ID instruction actually reads that source
//   id_halt           : ID instruction is HLT
//   ex_mem_read       : ID/EX MemRead
//   ex_dst_reg        : ID/EX destination register
//   ex_branch_taken   : branch in EX resolved taken
//   pc_wen            : PC write enable
//   pc_sel_branch     : PC loads the EX branch target
//   if_id_wen         : IF/ID write enable
//   if_id_flush       : IF/ID loads a NOP
//   id_ex_wen         : ID/EX write enable
//   id_ex_bubble      : zero control bits entering ID/EX
//   halted            : core halted
//   load_use_cnt      : load-use bubbles inserted
//   flush_cnt         : flush cycles issued
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cache_stall_n,
    input  logic [3:0]       id_src_reg1,
    input  logic [3:0]       id_src_reg2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_halt,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_dst_reg,
    input  logic             ex_branch_taken,
    output logic             pc_wen,
    output logic             pc_sel_branch,
    output logic             if_id_wen,
    output logic             if_id_flush,
    output logic             id_ex_wen,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Down-counter reload value after a taken branch. The branch cycle itself
    // is the first squash cycle, so only FLUSH_CYCLES-1 more are needed.
    localparam logic [2:0] FL_RELOAD   = 3'(FLUSH_CYCLES - 1);
    localparam logic       MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     state_q, state_d;
    logic [2:0] fl_cnt_q, fl_cnt_d;

    logic load_use_s;
    logic pc_wen_s, pc_sel_branch_s, if_id_wen_s, if_id_flush_s;
    logic id_ex_wen_s, id_ex_bubble_s, halted_s;

    // Load-use detection. Register 0 is hard-wired and never creates a hazard.
    always_comb begin
        load_use_s = ex_mem_read && (ex_dst_reg != 4'd0) &&
                     ((id_uses_src1 && (id_src_reg1 == ex_dst_reg)) ||
                      (id_uses_src2 && (id_src_reg2 == ex_dst_reg)));
    end

    // Output decode and next-state logic for the RUN/FLUSH/HALT controller.
    always_comb begin
        pc_wen_s        = 1'b0;
        pc_sel_branch_s = 1'b0;
        if_id_wen_s     = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_wen_s     = 1'b0;
        id_ex_bubble_s  = 1'b0;
        halted_s        = (state_q == ST_HALT);
        state_d         = state_q;
        fl_cnt_d        = fl_cnt_q;

        if (!cache_stall_n) begin
            // Freeze: all enables low, state and flush counter hold.
            pc_wen_s = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_FLUSH: begin
                    if (ex_branch_taken) begin
                        // Any same-cycle load-use or HLT is wrong-path.
                        pc_wen_s        = 1'b1;
                        pc_sel_branch_s = 1'b1;
                        if_id_wen_s     = 1'b1;
                        if_id_flush_s   = 1'b1;
                        id_ex_wen_s     = 1'b1;
                        id_ex_bubble_s  = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_d  = ST_FLUSH;
                            fl_cnt_d = FL_RELOAD;
                        end else begin
                            state_d  = ST_RUN;
                            fl_cnt_d = 3'd0;
                        end
                    end else if (state_q == ST_FLUSH) begin
                        pc_wen_s       = 1'b1;
                        if_id_wen_s    = 1'b1;
                        if_id_flush_s  = 1'b1;
                        id_ex_wen_s    = 1'b1;
                        id_ex_bubble_s = 1'b1;
                        fl_cnt_d       = fl_cnt_q - 3'd1;
                        if (fl_cnt_q == 3'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_FLUSH;
                        end
                    end else if (load_use_s) begin
                        // The load has left ID/EX next cycle, so the bubble
                        // clears itself without a state change.
                        id_ex_wen_s    = 1'b1;
                        id_ex_bubble_s = 1'b1;
                    end else if (id_halt) begin
                        // HLT itself is allowed into EX; fetch stops here.
                        id_ex_wen_s = 1'b1;
                        state_d     = ST_HALT;
                    end else begin
                        pc_wen_s    = 1'b1;
                        if_id_wen_s = 1'b1;
                        id_ex_wen_s = 1'b1;
                    end
                end
                ST_HALT: begin
                    id_ex_wen_s    = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end
                default: begin
                    state_d  = ST_RUN;
                    fl_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Controller state and flush down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            fl_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign pc_wen        = pc_wen_s;
    assign pc_sel_branch = pc_sel_branch_s;
    assign if_id_wen     = if_id_wen_s;
    assign if_id_flush   = if_id_flush_s;
    assign id_ex_wen     = id_ex_wen_s;
    assign id_ex_bubble  = id_ex_bubble_s;
    assign halted        = halted_s;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             lu_evt_s;
    logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counter updates. Only bubbles that actually issue count.
    always_comb begin
        lu_evt_s = cache_stall_n && (state_q == ST_RUN) && !ex_branch_taken &&
                   load_use_s;
        load_use_cnt_d = load_use_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        if (lu_evt_s && (load_use_cnt_q != CNT_MAX)) begin
            load_use_cnt_d = load_use_cnt_q + CNT_ONE;
        end else begin
            load_use_cnt_d = load_use_cnt_q;
        end
        if (if_id_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_use_cnt_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            load_use_cnt_q <= load_use_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign load_use_cnt = load_use_cnt_q;
    assign flush_cnt    = flush_cnt_q;
`else
    assign load_use_cnt = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and flow-control unit for the ID stage. It sits between the IF/ID register and the ID/EX register.
- Reads decoded ID-stage source registers and the ID/EX register outputs (mem_read, dst_reg, resolved taken branch).
- Generates write enables, flushes and bubble inserts for PC, IF/ID and ID/EX.
- A small FSM owns multi-cycle branch flushes and halt; cache stalls freeze everything.

Parameters:
FLUSH_CYCLES, 1, cycles of IF/ID+ID/EX squash after a taken branch (1..7)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cache_stall_n  in  1  0 = I/D cache miss in progress; freeze pipeline
id_src_reg1  in  4  ID-stage source register 1
id_src_reg2  in  4  ID-stage source register 2
id_uses_src1  in  1  ID instruction reads src1
id_uses_src2  in  1  ID instruction reads src2
id_halt  in  1  ID instruction is HLT
ex_mem_read  in  1  MemRead from ID/EX register
ex_dst_reg  in  4  dst_reg from ID/EX register
ex_branch_taken  in  1  branch in EX resolved taken (from ID/EX branch path)
pc_wen  out  1  PC register write enable
pc_sel_branch  out  1  PC loads EX branch target this cycle
if_id_wen  out  1  IF/ID write enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_wen  out  1  ID/EX write enable (drives its cache_stall_n)
id_ex_bubble  out  1  zero MemWrite/RegWrite/MemRead/branch into ID/EX
halted  out  1  core halted
load_use_cnt  out  CNT_W  load-use bubbles inserted (optional feature)
flush_cnt  out  CNT_W  flush cycles issued (optional feature)

Behaviour:
- States: RUN, FLUSH, HALT. 3-bit flush down-counter fl_cnt.
- Reset (async, rst=1): state RUN, fl_cnt 0, counters 0, halted 0. Outputs are combinational from state and inputs; in RUN with idle inputs: pc_wen=1, if_id_wen=1, id_ex_wen=1, all others 0.
- load_use = ex_mem_read & (ex_dst_reg != 0) & ((id_uses_src1 & id_src_reg1==ex_dst_reg) | (id_uses_src2 & id_src_reg2==ex_dst_reg)). Register 0 never causes a hazard.
- Priority, highest first: cache stall > taken branch > FLUSH state > load_use > halt.
- cache_stall_n=0, any state: pc_wen=if_id_wen=id_ex_wen=0, flush/bubble/pc_sel_branch=0. State, fl_cnt and counters hold.
- RUN, ex_branch_taken=1: pc_sel_branch=1, pc_wen=1, if_id_flush=1, id_ex_bubble=1.
  - FLUSH_CYCLES=1: stay RUN.
  - Otherwise: fl_cnt <= FLUSH_CYCLES-1, go FLUSH.
  - Overrides a same-cycle load_use or id_halt (both are wrong-path).
- FLUSH: pc_wen=1, if_id_flush=1, id_ex_bubble=1, pc_sel_branch=0. fl_cnt decrements each unstalled cycle; at fl_cnt==1, next state RUN. A taken branch in FLUSH restarts the sequence as in RUN.
- RUN, load_use (no branch): one-cycle bubble. pc_wen=0, if_id_wen=0, id_ex_bubble=1, id_ex_wen=1. Next cycle ex_mem_read=0, so the stall self-clears; no state change.
- RUN, id_halt (no branch, no load_use): pc_wen=0, if_id_wen=0, id_ex_bubble=0 (HLT enters EX). Go HALT.
- HALT: halted=1, pc_wen=0, if_id_wen=0, id_ex_bubble=1. Exit only by rst.
- Reset mid-FLUSH or mid-stall: immediate return to RUN, fl_cnt cleared.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: load_use_cnt increments on each unstalled load-use bubble cycle; flush_cnt increments on each unstalled cycle with if_id_flush=1. Both saturate at all-ones and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- After rst release, idle inputs -> pc_wen=1, if_id_wen=1, id_ex_wen=1, halted=0, all other outputs 0.
- ex_mem_read=1, ex_dst_reg=5, id_uses_src2=1, id_src_reg2=5 for one cycle -> that cycle pc_wen=0, if_id_wen=0, id_ex_bubble=1; next cycle (ex_mem_read=0) normal flow; load_use_cnt=1 if enabled. Same case with ex_dst_reg=0 -> no stall.
- FLUSH_CYCLES=3, ex_branch_taken pulse -> pc_sel_branch=1 for 1 cycle, if_id_flush=1 for exactly 3 cycles, then RUN; flush_cnt=3.
- Taken branch, load_use and id_halt in the same cycle -> flush only, halted stays 0.
- cache_stall_n=0 for 4 cycles during FLUSH (fl_cnt=1) -> all wen=0 and state frozen; after release, one more flush cycle then RUN.
- id_halt=1 -> halted=1 next cycle and pc_wen=0 thereafter; rst asserted asynchronously mid-cycle -> halted=0 immediately.
